md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MUL_LAT, default 5, busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter DIV_LAT, default 10, busy cycles for div/divu (legal range 1..15).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 md_valid  input  1  EX-stage instruction is valid (not stalled or flushed).
REQ-006 md_func  input  3  encoding: 0 none, 1 mthi, 2 mtlo, 3 mult/multu, 4 div/divu; 5..7 treated as 0.
REQ-007 md_sign  input  1  1 means signed (mult/div), 0 means unsigned.
REQ-008 md_read  input  1  mfhi or mflo in EX.
REQ-009 cancel  input  1  exception flush of the EX instruction this cycle.
REQ-010 rs_val  input  32  operand A (dividend or multiplicand; mthi/mtlo source).
REQ-011 rt_val  input  32  operand B (divisor or multiplier).
REQ-012 busy  output  1  a mult or div operation is in flight.
REQ-013 stall_req  output  1  combinational request to freeze IF/ID/EX.
REQ-014 hi_out  output  32  architectural HI register.
REQ-015 lo_out  output  32  architectural LO register.

Function
REQ-016 The block SHALL contain two states: IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-017 Accept condition: md_valid & !cancel & !stall_req.
- Accepted func 3 in IDLE SHALL latch the operands and md_sign, load cnt=MUL_LAT, and move to RUN.
- Accepted func 4 in IDLE SHALL do the same with cnt=DIV_LAT.
REQ-018 Accepted func 1 SHALL write HI<=rs_val on the next edge; accepted func 2 SHALL write LO<=rs_val on the next edge. The FSM does not change state.
REQ-019 In RUN, cnt SHALL decrement each cycle. On the edge where cnt==1, HI/LO SHALL take the result and the FSM SHALL return to IDLE.
REQ-020 busy SHALL equal (state==RUN). busy is high for exactly MUL_LAT or DIV_LAT cycles, starting the cycle after acceptance.
REQ-021 stall_req SHALL equal busy & (md_read | (md_valid & md_func in 1..4)).
- A stalled request SHALL NOT be latched; it is re-presented by the pipeline.
REQ-022 No stall SHALL occur in the acceptance cycle. Non-MD instructions SHALL never stall.
REQ-023 Multiply: the 64-bit product is signed or unsigned per md_sign. HI SHALL receive bits [63:32] and LO SHALL receive bits [31:0].
REQ-024 Divide: LO SHALL receive the quotient, truncated toward zero. HI SHALL receive the remainder, which carries the sign of the dividend.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-026 cancel asserted with a start SHALL suppress it: no state change and no HI/LO write.
REQ-027 cancel while in RUN SHALL be ignored; the in-flight operation completes.
REQ-028 hi_out/lo_out SHALL be registered values. A result is visible the first cycle busy is low.
REQ-029 md_read issued in the cycle busy falls SHALL see the new result.

Reset
REQ-030 reset SHALL force state=IDLE, cnt=0, HI=0, LO=0, busy=0.
REQ-031 reset asserted in RUN SHALL abort the operation with no result write, and reset SHALL take priority over every other input.
REQ-032 stall_req SHALL be 0 during reset and during the cycle after it.

Configuration
REQ-033 Macro MD_DIV_ZERO_HOLD_EN selects divide-by-zero behaviour.
REQ-034 With MD_DIV_ZERO_HOLD_EN defined, div/divu with rt_val==0 SHALL run the full DIV_LAT cycles and leave HI/LO unchanged.
REQ-035 With MD_DIV_ZERO_HOLD_EN undefined, divide by zero SHALL write LO=0xFFFFFFFF and HI=rs_val, after the same latency.

Verification
REQ-036 multu 0xFFFFFFFF*0x2 -> busy high 5 cycles -> HI=0x1, LO=0xFFFFFFFE.
REQ-037 signed div -7/2 -> busy high 10 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; mflo presented in busy cycles 1..10 -> stall_req=1 each cycle, 0 after.
REQ-038 mthi 0x1234 when idle -> next cycle hi_out=0x1234. mtlo issued during a mult -> stalled, then applied after the mult completes, overwriting its LO.
REQ-039 mult start with cancel=1 -> busy stays 0, HI/LO unchanged. cancel pulsed in busy cycle 2 -> result still written.
REQ-040 reset in busy cycle 3 of div -> next cycle busy=0, HI=LO=0, and no late write.
REQ-041 divu 5/0 -> with MD_DIV_ZERO_HOLD_EN, HI/LO unchanged. Without it, LO=0xFFFFFFFF, HI=5.

Source files
------------

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning the HI/LO registers: holds a mult/div busy for a fixed latency and stalls dependent MD instructions.
// Optional feature: define MD_DIV_ZERO_HOLD_EN to leave HI/LO untouched on divide by zero.
module md_sequencer #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic        md_read,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] FUNC_MTHI = 3'd1;
    localparam logic [2:0] FUNC_MTLO = 3'd2;
    localparam logic [2:0] FUNC_MULT = 3'd3;
    localparam logic [2:0] FUNC_DIV  = 3'd4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sign;
    logic        op_div;

    logic        md_is_op;
    logic        accept;

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic        div_zero;
    logic [31:0] divisor;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy      = (state == RUN);
    assign md_is_op  = md_valid && (md_func >= FUNC_MTHI) && (md_func <= FUNC_DIV);
    // Reset gates the stall so the pipeline is never frozen while the block is being cleared.
    assign stall_req = !reset && busy && (md_read || md_is_op);
    assign accept    = md_valid && !cancel && !stall_req;

    // Results are formed on magnitudes so signed and unsigned share one datapath.
    assign neg_a    = op_sign && op_a[31];
    assign neg_b    = op_sign && op_b[31];
    assign mag_a    = neg_a ? (~op_a + 32'd1) : op_a;
    assign mag_b    = neg_b ? (~op_b + 32'd1) : op_b;

    assign prod_mag = {32'd0, mag_a} * {32'd0, mag_b};
    assign prod     = (neg_a ^ neg_b) ? (~prod_mag + 64'd1) : prod_mag;

    assign div_zero = (op_b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign quo_mag  = mag_a / divisor;
    assign rem_mag  = mag_a % divisor;
    assign quo      = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem      = neg_a ? (~rem_mag + 32'd1) : rem_mag;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op_div) begin
            if (div_zero) begin
`ifdef MD_DIV_ZERO_HOLD_EN
                res_hi = hi_out;
                res_lo = lo_out;
`else
                res_hi = op_a;
                res_lo = 32'hFFFF_FFFF;
`endif
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_sign <= 1'b0;
            op_div  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (md_func)
                            FUNC_MTHI: hi_out <= rs_val;
                            FUNC_MTLO: lo_out <= rs_val;
                            FUNC_MULT: begin
                                op_a    <= rs_val;
                                op_b    <= rt_val;
                                op_sign <= md_sign;
                                op_div  <= 1'b0;
                                cnt     <= 4'(MUL_LAT);
                                state   <= RUN;
                            end
                            FUNC_DIV: begin
                                op_a    <= rs_val;
                                op_b    <= rt_val;
                                op_sign <= md_sign;
                                op_div  <= 1'b1;
                                cnt     <= 4'(DIV_LAT);
                                state   <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // cancel is deliberately not looked at: an issued operation always completes.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi_out <= res_hi;
                        lo_out <= res_lo;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed corner cases then randomized traffic against a
// longint-arithmetic reference model; completions are checked by an independent monitor.
`timescale 1ns/1ps
module tb_md_sequencer;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_func;
    logic        md_sign;
    logic        md_read;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_valid  (md_valid),
        .md_func   (md_func),
        .md_sign   (md_sign),
        .md_read   (md_read),
        .cancel    (cancel),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [2:0]  nonmd[4] = '{3'd0, 3'd5, 3'd6, 3'd7};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] ref_md(input bit is_div, input bit s, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (!is_div) begin
            p = 64'(sa * sb);
            return p;
        end
        if (b == 32'd0) begin
`ifdef MD_DIV_ZERO_HOLD_EN
            return {cur_hi, cur_lo};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end
        qv = 64'(sa / sb);
        rv = 64'(sa % sb);
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        md_valid = 1'b0;
        md_func  = 3'd0;
        md_sign  = 1'b0;
        md_read  = 1'b0;
        cancel   = 1'b0;
    endtask

    // Model update plus scoreboard push for a mult/div that is going to be accepted.
    task automatic expect_md(input string nm, input logic [2:0] f, input bit s,
                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        r    = ref_md(f == 3'd4, s, a, b, m_hi, m_lo);
        m_hi = r[63:32];
        m_lo = r[31:0];
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.lat  = (f == 3'd4) ? DIV_LAT : MUL_LAT;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input bit c);
        md_valid = 1'b1;
        md_func  = f;
        md_sign  = s;
        rs_val   = a;
        rt_val   = b;
        cancel   = c;
        @(negedge clk);
        check("no_stall_on_issue", stall_req, 0);
        tick();
        drive_idle();
    endtask

    // Waits for busy to drop while presenting non-MD traffic and stray cancels, which must never stall.
    task automatic wait_done(input string nm);
        int n = 0;
        forever begin
            md_valid = 1'($urandom);
            md_func  = nonmd[$urandom_range(0, 3)];
            cancel   = 1'($urandom);
            md_read  = 1'b0;
            @(negedge clk);
            check({nm, "_nonmd_stall"}, stall_req, 0);
            if (!busy) break;
            n++;
            if (n > 40) begin
                check({nm, "_timeout"}, busy, 0);
                break;
            end
            tick();
        end
        tick();
        drive_idle();
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input bit s,
                          input logic [31:0] a, input logic [31:0] b, input bit c);
        bit is_md;
        is_md = (f == 3'd3) || (f == 3'd4);
        if (is_md && !c) expect_md(nm, f, s, a, b);
        else if (!c && f == 3'd1) m_hi = a;
        else if (!c && f == 3'd2) m_lo = a;
        issue(f, s, a, b, c);
        if (is_md && !c) begin
            wait_done(nm);
        end else begin
            @(negedge clk);
            check({nm, "_busy"}, busy, 0);
            check({nm, "_hi"}, hi_out, m_hi);
            check({nm, "_lo"}, lo_out, m_lo);
            tick();
        end
    endtask

    // Monitor: every falling edge of busy outside reset is a completion to be scored.
    initial begin
        bit   prev_busy = 1'b0;
        int   run_len   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                run_len   = 0;
            end else begin
                if (busy) begin
                    run_len++;
                end else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_res_hi"}, hi_out, e.hi);
                        check({e.name, "_res_lo"}, lo_out, e.lo);
                        check({e.name, "_busy_len"}, run_len, e.lat);
                    end
                    run_len = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held_hi;
        logic [31:0] held_lo;

        drive_idle();
        rs_val = 32'd0;
        rt_val = 32'd0;
        reset  = 1'b1;
        md_valid = 1'b1;
        md_func  = 3'd3;
        md_read  = 1'b1;
        tick();
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_hi", hi_out, 0);
        check("reset_lo", lo_out, 0);
        check("reset_stall", stall_req, 0);
        tick();
        reset = 1'b0;
        drive_idle();
        m_hi = 32'd0;
        m_lo = 32'd0;

        // multu 0xFFFFFFFF * 2
        run_op("multu_ffff", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_ffff_hi_const", hi_out, 32'h1);
        check("multu_ffff_lo_const", lo_out, 32'hFFFF_FFFE);

        // signed div -7/2 with mflo held every cycle
        expect_md("div_m7_2", 3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        md_valid = 1'b1;
        md_func  = 3'd0;
        md_read  = 1'b1;
        for (int i = 1; i <= DIV_LAT + 1; i++) begin
            @(negedge clk);
            check($sformatf("mflo_stall_cycle_%0d", i), stall_req, (i <= DIV_LAT) ? 1 : 0);
            tick();
        end
        drive_idle();
        check("div_m7_2_lo_const", lo_out, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", hi_out, 32'hFFFF_FFFF);

        // mthi while idle
        run_op("mthi_idle", 3'd1, 1'b0, 32'h1234, 32'd0, 1'b0);
        check("mthi_idle_const", hi_out, 32'h1234);

        // mtlo presented during a mult: stalled, then overwrites the mult LO
        expect_md("mult_then_mtlo", 3'd3, 1'b1, 32'h1234_5678, 32'hFFFF_FF00);
        issue(3'd3, 1'b1, 32'h1234_5678, 32'hFFFF_FF00, 1'b0);
        md_valid = 1'b1;
        md_func  = 3'd2;
        rs_val   = 32'hCAFE_F00D;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall_req) break;
            n++;
            if (n > 40) break;
            tick();
        end
        tick();
        drive_idle();
        check("mtlo_stall_cycles", n, MUL_LAT);
        m_lo = 32'hCAFE_F00D;
        @(negedge clk);
        check("mtlo_after_mult_lo", lo_out, m_lo);
        check("mtlo_after_mult_hi", hi_out, m_hi);
        tick();

        // start suppressed by cancel, then cancel pulsed in busy cycle 2
        run_op("mult_cancelled", 3'd3, 1'b1, 32'd7, 32'd9, 1'b1);
        expect_md("mult_cancel_mid", 3'd3, 1'b0, 32'd1000, 32'd3000);
        issue(3'd3, 1'b0, 32'd1000, 32'd3000, 1'b0);
        tick();
        md_valid = 1'b1;
        cancel   = 1'b1;
        tick();
        drive_idle();
        wait_done("mult_cancel_mid");
        check("mult_cancel_mid_lo_const", lo_out, 32'd3_000_000);

        // reset during busy cycle 3 of a div: aborted, no late write
        issue(3'd4, 1'b0, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        reset    = 1'b1;
        md_valid = 1'b1;
        md_read  = 1'b1;
        @(negedge clk);
        check("stall_during_reset", stall_req, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        check("stall_after_reset", stall_req, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        drive_idle();
        repeat (DIV_LAT + 2) tick();
        check("abort_no_late_hi", hi_out, 0);
        check("abort_no_late_lo", lo_out, 0);

        // divu 5/0 with known prior HI/LO
        run_op("pre_mthi", 3'd1, 1'b0, 32'hAAAA_5555, 32'd0, 1'b0);
        run_op("pre_mtlo", 3'd2, 1'b0, 32'h5555_AAAA, 32'd0, 1'b0);
        held_hi = hi_out;
        held_lo = lo_out;
        run_op("divu_zero", 3'd4, 1'b0, 32'd5, 32'd0, 1'b0);
`ifdef MD_DIV_ZERO_HOLD_EN
        check("divu_zero_hi_const", hi_out, held_hi);
        check("divu_zero_lo_const", lo_out, held_lo);
`else
        check("divu_zero_hi_const", hi_out, 32'd5);
        check("divu_zero_lo_const", lo_out, 32'hFFFF_FFFF);
`endif

        // signed overflow case
        run_op("div_ovf", 3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", lo_out, 32'h8000_0000);
        check("div_ovf_hi_const", hi_out, 32'h0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d_f%0d", i, f), f, 1'($urandom), a, b,
                   ($urandom_range(0, 7) == 0));
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
